// File: rtl/tx_fifo_pkg.sv
// rtl/tx_fifo_pkg.sv - shared defaults and depth helper for the TX byte FIFO
// Contents:
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default entry width and address width
//   fifo_depth(aw)                  : number of entries for an aw-bit address
package tx_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 10;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/tx_fifo_ram.sv
// rtl/tx_fifo_ram.sv - simple dual-port RAM, synchronous write, registered read
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : async active-low reset, clears the read register only
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_re     : read enable, loads o_rdata from mem[i_raddr]
//   i_raddr  : read address
//   o_rdata  : registered read data, holds when i_re is low
module tx_fifo_ram
  import tx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage array has no reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tx_fifo_sync.sv
// rtl/tx_fifo_sync.sv - single-clock TX byte FIFO with almost-full/almost-empty flags
// Ports:
//   i_clk, i_rst_n : clock (rising edge) and async active-low reset
//   i_push/i_wdata : producer write request and data
//   i_pop          : consumer read request
//   o_rdata        : registered read data, valid the cycle after an accepted pop
//   o_afull        : count >= DEPTH - AFULL_MARGIN
//   o_aempty       : count <= AEMPTY_MARGIN
//   o_full/o_empty : count == DEPTH / count == 0
module tx_fifo_sync
  import tx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int AFULL_MARGIN  = 4,
  parameter int AEMPTY_MARGIN = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_afull,
  output logic                  o_aempty,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int                DEPTH       = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] C_DEPTH     = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AFULL_TH  = (ADDR_WIDTH+1)'(DEPTH - AFULL_MARGIN);
  localparam logic [ADDR_WIDTH:0] C_AEMPTY_TH = (ADDR_WIDTH+1)'(AEMPTY_MARGIN);
  localparam logic [ADDR_WIDTH:0] C_CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_afull;
  logic                  r_aempty;

  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  // Gating on the registered flags gives both precedence rules for free:
  // a full FIFO refuses the push even with a concurrent pop, and an empty
  // FIFO refuses the pop even with a concurrent push (no bypass).
  assign w_push_ok = i_push & ~r_full;
  assign w_pop_ok  = i_pop  & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_nxt = r_count + C_CNT_ONE;
    end else if (w_pop_ok && !w_push_ok) begin
      w_count_nxt = r_count - C_CNT_ONE;
    end
  end

  // Flags are derived from the next count so they change on the same edge
  // as the count itself.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + C_PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + C_PTR_ONE;
      end
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == C_DEPTH);
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= C_AFULL_TH);
      r_aempty <= (w_count_nxt <= C_AEMPTY_TH);
    end
  end

  tx_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_push_ok),
    .i_waddr (r_wptr),
    .i_wdata (i_wdata),
    .i_re    (w_pop_ok),
    .i_raddr (r_rptr),
    .o_rdata (o_rdata)
  );

  assign o_full   = r_full;
  assign o_empty  = r_empty;
  assign o_afull  = r_afull;
  assign o_aempty = r_aempty;

endmodule

// File: tb/tb_tx_fifo_sync.sv
// tb/tb_tx_fifo_sync.sv - self-checking bench for tx_fifo_sync against a queue model
module tb_tx_fifo_sync;

  localparam int DEPTH = 1024;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       push;
  logic       pop;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       afull;
  logic       aempty;
  logic       full;
  logic       empty;

  logic [7:0] q [$];
  logic [7:0] m_rdata;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  tx_fifo_sync dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_push   (push),
    .i_wdata  (wdata),
    .i_pop    (pop),
    .o_rdata  (rdata),
    .o_afull  (afull),
    .o_aempty (aempty),
    .o_full   (full),
    .o_empty  (empty)
  );

  // One clock of stimulus; the queue model applies the acceptance rules to
  // the state before the edge. Returns at the following falling edge.
  task automatic step(input logic p, input logic r, input logic [7:0] d);
    bit pa;
    bit ra;
    push  = p;
    pop   = r;
    wdata = d;
    @(posedge clk);
    pa = p && (q.size() < DEPTH);
    ra = r && (q.size() > 0);
    if (ra) m_rdata = q.pop_front();
    if (pa) q.push_back(d);
    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    wdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b exp 1", aempty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (afull !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", afull); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", rdata); end
    rst_n = 1'b1;
    q.delete();
    m_rdata = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int k = 0; k < 1026; k++) begin
      step(1'b1, 1'b0, 8'((k + 1) % 256));
      step(1'b0, 1'b0, 8'h00);
      checks++; if (aempty !== (q.size() <= 4)) begin errors++; $display("FAIL fill_aempty k=%0d got %b exp %b", k, aempty, q.size() <= 4); end
      checks++; if (afull !== (q.size() >= 1020)) begin errors++; $display("FAIL fill_afull k=%0d got %b exp %b", k, afull, q.size() >= 1020); end
      checks++; if (full !== (q.size() == DEPTH)) begin errors++; $display("FAIL fill_full k=%0d got %b exp %b", k, full, q.size() == DEPTH); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty k=%0d got %b exp 0", k, empty); end
    end
    checks++; if (q.size() != DEPTH || full !== 1'b1) begin errors++; $display("FAIL fill_final full=%b model=%0d exp 1/1024", full, q.size()); end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 1026; k++) begin
      step(1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      checks++; if (rdata !== ((k < 1024) ? 8'((k + 1) % 256) : 8'h00)) begin errors++; $display("FAIL drain_rdata k=%0d got %h exp %h", k, rdata, (k < 1024) ? 8'((k + 1) % 256) : 8'h00); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL drain_full k=%0d got %b exp 0", k, full); end
      checks++; if (empty !== (k >= 1023)) begin errors++; $display("FAIL drain_empty k=%0d got %b exp %b", k, empty, k >= 1023); end
      checks++; if (afull !== (q.size() >= 1020)) begin errors++; $display("FAIL drain_afull k=%0d got %b exp %b", k, afull, q.size() >= 1020); end
      checks++; if (aempty !== (q.size() <= 4)) begin errors++; $display("FAIL drain_aempty k=%0d got %b exp %b", k, aempty, q.size() <= 4); end
    end
  endtask

  task automatic test_wrap();
    int n;
    for (int pass = 0; pass < 2; pass++) begin
      n = (pass == 0) ? 1000 : 100;
      for (int k = 0; k < n; k++) step(1'b1, 1'b0, 8'($urandom));
      for (int k = 0; k < n; k++) begin
        step(1'b0, 1'b1, 8'h00);
        checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL wrap_rdata pass=%0d k=%0d got %h exp %h", pass, k, rdata, m_rdata); end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty pass=%0d got %b exp 1", pass, empty); end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] d;
    logic [7:0] prev;
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 8'($urandom));
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 8'($urandom));
      checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL sim10_rdata k=%0d got %h exp %h", k, rdata, m_rdata); end
      checks++; if (empty !== 1'b0 || aempty !== 1'b0) begin errors++; $display("FAIL sim10_flags k=%0d got e=%b ae=%b exp 0/0", k, empty, aempty); end
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL sim10_drain k=%0d got %h exp %h", k, rdata, m_rdata); end
      checks++; if (empty !== (k == 9)) begin errors++; $display("FAIL sim10_empty k=%0d got %b exp %b", k, empty, k == 9); end
    end

    prev = rdata;
    d = 8'($urandom);
    step(1'b1, 1'b1, d);
    checks++; if (rdata !== prev) begin errors++; $display("FAIL sim0_rdata_hold got %h exp %h", rdata, prev); end
    checks++; if (empty !== 1'b0 || aempty !== 1'b1) begin errors++; $display("FAIL sim0_flags got e=%b ae=%b exp 0/1", empty, aempty); end
    step(1'b0, 1'b1, 8'h00);
    checks++; if (rdata !== d) begin errors++; $display("FAIL sim0_pop got %h exp %h", rdata, d); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sim0_empty got %b exp 1", empty); end

    for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b0, 8'($urandom));
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL sim1024_full_pre got %b exp 1", full); end
    d = 8'($urandom);
    step(1'b1, 1'b1, d);
    checks++; if (full !== 1'b0 || afull !== 1'b1) begin errors++; $display("FAIL sim1024_flags got f=%b af=%b exp 0/1", full, afull); end
    checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL sim1024_rdata got %h exp %h", rdata, m_rdata); end
    for (int k = 0; k < 1023; k++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL sim1024_drain k=%0d got %h exp %h", k, rdata, m_rdata); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sim1024_empty got %b exp 1", empty); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      if (k < 1500) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 8'($urandom));
      else          step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
      checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata k=%0d got %h exp %h", k, rdata, m_rdata); end
      checks++; if ({full, afull, aempty, empty} !== {q.size() == DEPTH, q.size() >= 1020, q.size() <= 4, q.size() == 0}) begin
        errors++; $display("FAIL rnd_flags k=%0d got %b exp %b", k, {full, afull, aempty, empty}, {q.size() == DEPTH, q.size() >= 1020, q.size() <= 4, q.size() == 0});
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    while (q.size() > 0) step(1'b0, 1'b1, 8'h00);
    for (int k = 0; k < 500; k++) step(1'b1, 1'b0, 8'($urandom));
    step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 8'($urandom));
    #2 rst_n = 1'b0;
    #1;
    checks++; if (empty !== 1'b1 || aempty !== 1'b1) begin errors++; $display("FAIL arst_empty got e=%b ae=%b exp 1/1", empty, aempty); end
    checks++; if (full !== 1'b0 || afull !== 1'b0) begin errors++; $display("FAIL arst_full got f=%b af=%b exp 0/0", full, afull); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL arst_rdata got %h exp 00", rdata); end
    q.delete();
    m_rdata = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d = 8'($urandom);
    step(1'b1, 1'b0, d);
    step(1'b0, 1'b1, 8'h00);
    checks++; if (rdata !== d) begin errors++; $display("FAIL arst_newdata got %h exp %h", rdata, d); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst_post_empty got %b exp 1", empty); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_fifo_sync.md
Name: tx_fifo_sync

Overview:
Single-clock synchronous FIFO that buffers transmit bytes between a producer and the TX serializer. Storage is a DEPTH = 2^ADDR_WIDTH entry RAM with binary read/write pointers and an occupancy counter. The producer pushes with i_push/i_wdata. The consumer pops with i_pop and receives registered o_rdata. Almost-full and almost-empty flags provide early flow control.

Parameters:
DATA_WIDTH, 8, width of each entry in bits.
ADDR_WIDTH, 10, log2 of depth; DEPTH = 1024 entries at default.
AFULL_MARGIN, 4, o_afull asserts when count >= DEPTH - AFULL_MARGIN.
AEMPTY_MARGIN, 4, o_aempty asserts when count <= AEMPTY_MARGIN.

Ports:
i_clk  in  1  single clock; all logic on rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_push  in  1  write request, one entry per cycle while high.
i_wdata  in  DATA_WIDTH  write data, sampled with i_push.
i_pop  in  1  read request, one entry per cycle while high.
o_rdata  out  DATA_WIDTH  read data, registered.
o_afull  out  1  almost-full flag, registered.
o_aempty  out  1  almost-empty flag, registered.
o_full  out  1  count == DEPTH.
o_empty  out  1  count == 0.

Behaviour:
- Reset (i_rst_n low, asynchronous assert):
  - Pointers, count and o_rdata clear to 0.
  - o_empty=1, o_aempty=1, o_full=0, o_afull=0.
  - RAM contents are not reset.
  - Deassertion is synchronous to i_clk; upstream provides the synchronizer.
- Push accepted when i_push=1 and o_full=0:
  - mem[wptr] <= i_wdata.
  - wptr increments modulo DEPTH (ADDR_WIDTH-bit natural wrap).
- Push while full is dropped silently; no state change.
- Full-state precedence: push is blocked when full even if pop occurs in the same cycle; the pop proceeds.
- Pop accepted when i_pop=1 and o_empty=0:
  - o_rdata <= mem[rptr] on that clock edge, so data is visible the cycle after pop (1-cycle latency).
  - rptr increments modulo DEPTH.
- Pop while empty is ignored; o_rdata holds its previous value.
- Empty-state rule: no write-to-read bypass. When empty, push and pop in the same cycle accepts only the push.
- o_rdata holds its value whenever no pop is accepted.
- Count is ADDR_WIDTH+1 bits:
  - +1 on accepted push only.
  - -1 on accepted pop only.
  - Unchanged when both or neither are accepted.
- Flag timing: all flags are computed from next-count and registered, so they reflect the count after the current edge with zero added lag.
- Thresholds: o_afull at count >= 1020 and o_aempty at count <= 4 (default parameters).
- Reset mid-operation: immediate return to the reset state; all stored data is discarded.

Decomposition:
- Shared package tx_fifo_pkg holds:
  - default DATA_WIDTH / ADDR_WIDTH constants;
  - a function computing DEPTH from ADDR_WIDTH.
- One natural sub-module, tx_fifo_ram: simple dual-port RAM with a synchronous write port and a registered read port. It is clocked on i_clk and is inferable as block RAM.
- Pointer, count and flag logic stays in the top module.

Test Plan:
- Reset, no traffic -> o_empty=1, o_aempty=1, o_full=0, o_afull=0, o_rdata=0x00.
- Fill: 1026 pushes of (k+1) mod 256, pushing every other cycle:
  - o_aempty drops after the 5th accepted push;
  - o_afull rises at count 1020;
  - o_full rises at count 1024;
  - pushes 1025–1026 are dropped and count stays 1024.
- Drain: 1026 pops, every other cycle:
  - o_rdata sequence is 0x01,0x02,…,0xFF,0x00,… for 1024 entries;
  - o_full clears after the first pop;
  - o_empty sets after the 1024th pop;
  - pops 1025–1026 are ignored and o_rdata holds 0x00.
- Pointer wrap: push 1000, pop 1000, push 100, pop 100 -> data is returned in order across the address wrap; count returns to 0.
- Simultaneous push+pop:
  - at count 10, count stays 10 and data order is preserved;
  - at count 0, the push is accepted, the pop is ignored, and count becomes 1;
  - at count 1024, the pop is accepted, the push is dropped, and count becomes 1023.
- Async reset asserted mid-fill at count 500 -> all outputs reach reset values without a clock edge. After release, a single push and pop returns the new data.
